ex_gcd_arbiter: RTL and testbench
=================================

Name: ex_gcd_arbiter

Overview:
- Shares one GCD unit (32-bit request {a,b}, 16-bit response) among NREQ requesters.
- Each requester has its own val/rdy request and response interfaces.
- Requests are granted round-robin and forwarded to the GCD unit.
- A tag FIFO records which requester each in-flight request came from. GCD responses return in order and are steered back to that requester.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TAG_DEPTH, 2, maximum number of in-flight GCD requests (power of 2, >=1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_msg  in  NREQ*32  requester i's request is bits [32i+31:32i], formatted {a[15:0], b[15:0]}.
- req_val  in  NREQ  per-requester request valid.
- req_rdy  out  NREQ  per-requester request ready.
- resp_msg  out  16  response data, broadcast to all requesters.
- resp_val  out  NREQ  per-requester response valid.
- resp_rdy  in  NREQ  per-requester response ready.
- gcd_req_msg  out  32  request to the GCD unit.
- gcd_req_val  out  1  request valid to the GCD unit.
- gcd_req_rdy  in  1  request ready from the GCD unit.
- gcd_resp_msg  in  16  response from the GCD unit.
- gcd_resp_val  in  1  response valid from the GCD unit.
- gcd_resp_rdy  out  1  response ready to the GCD unit.

Behaviour:
- State: round-robin priority pointer prio (clog2(NREQ) bits) and a tag FIFO (TAG_DEPTH entries of clog2(NREQ) bits, with head, tail and count).
- Reset (asynchronous, on reset==0):
  - prio=0, FIFO empty.
  - All outputs 0: req_rdy, resp_val, gcd_req_val, gcd_resp_rdy.
  - A reset mid-operation discards all in-flight tags. The GCD unit shares the same reset, so there are no stale responses.
- Grant (combinational): grant index g = first i with req_val[i]=1, searching from prio upward and wrapping modulo NREQ.
- full = (count==TAG_DEPTH); empty = (count==0).
- Request side:
  - gcd_req_val = |req_val & !full.
  - gcd_req_msg = req_msg slice of g.
  - req_rdy[i] = (i==g) & |req_val & gcd_req_rdy & !full.
  - At most one req_rdy bit is high, and only for a valid requester.
  - No combinational path from req_val[i] to req_rdy[j] for j≠i, other than through grant selection.
- Request fire (gcd_req_val & gcd_req_rdy):
  - Push g into the FIFO.
  - prio <= (g+1) mod NREQ.
  - Without a fire, prio holds.
- Full FIFO: push is blocked even if a pop occurs in the same cycle (conservative; removes the rdy-to-rdy combinational path).
- Response side:
  - h = FIFO head tag.
  - resp_val[i] = (i==h) & gcd_resp_val & !empty.
  - gcd_resp_rdy = !empty & resp_rdy[h].
  - resp_msg = gcd_resp_msg.
- Response fire: pop the FIFO.
- Push and pop in the same cycle with the FIFO not full: count unchanged; head and tail both advance.
- gcd_resp_val=1 while the FIFO is empty is a protocol violation: gcd_resp_rdy stays 0 and no resp_val is asserted.
- Latency: arbiter adds 0 cycles on both paths; all forwarding is combinational.
- Throughput: one request per cycle, up to TAG_DEPTH outstanding.
- Pointer and FIFO indices wrap modulo NREQ and TAG_DEPTH respectively.
- trace task: prints the granted index, or '.' when no request fires, then the FIFO count.

Optional Feature:
- Macro: EX_GCD_ARBITER_PERF_EN.
- When defined:
  - Adds output perf_grants (NREQ*16): per-requester 16-bit grant counters, incremented on each request fire for that requester, saturating at 16'hffff.
  - Adds output perf_stall (16): counts cycles with |req_val=1 and no request fire, also saturating.
  - All counters reset to 0.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Single requester: requester 0 sends (27,15) then (21,49) with GCD delay 0 -> resp_val[0] returns 3 then 7; other resp_val bits stay 0.
- Fairness: all 4 requesters hold req_val=1 continuously, FIFO never full -> grant order 0,1,2,3,0,1,...; each requester receives its own results, e.g. 1:(40,40)->40 and 2:(250,190)->10.
- Backpressure, TAG_DEPTH=2, gcd_resp_rdy path stalled via resp_rdy=0 -> after 2 fires, gcd_req_val=0 and all req_rdy=0. Raising resp_rdy pops one entry, and a new request fires only in the following cycle.
- Response steering under sink delay: requesters 3 and 1 fire in that order with sink random delay 5 -> 3 receives its result before 1; resp_val never asserts for a requester with no tag at the head.
- Reset mid-operation: reset driven low with 2 tags in flight -> immediately req_rdy=0, resp_val=0, gcd_req_val=0. After release, prio=0, and requester 0 wins when all request.
- With EX_GCD_ARBITER_PERF_EN: 9 requests from requester 2 -> perf_grants[2]=9, other grant counters 0, perf_stall equals the counted blocked cycles.

Source files
------------

// File: rtl/ex_gcd_arbiter.sv
// Round-robin arbiter sharing one GCD unit among NREQ requesters; a tag FIFO steers
// in-order GCD responses back. Optional perf counters: define EX_GCD_ARBITER_PERF_EN.
module ex_gcd_arbiter #(
  parameter int NREQ      = 4,
  parameter int TAG_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ*32-1:0]   req_msg,
  input  logic [NREQ-1:0]      req_val,
  output logic [NREQ-1:0]      req_rdy,
  output logic [15:0]          resp_msg,
  output logic [NREQ-1:0]      resp_val,
  input  logic [NREQ-1:0]      resp_rdy,
  output logic [31:0]          gcd_req_msg,
  output logic                 gcd_req_val,
  input  logic                 gcd_req_rdy,
  input  logic [15:0]          gcd_resp_msg,
  input  logic                 gcd_resp_val,
  output logic                 gcd_resp_rdy
`ifdef EX_GCD_ARBITER_PERF_EN
  ,
  output logic [NREQ*16-1:0]   perf_grants,
  output logic [15:0]          perf_stall
`endif
);

  localparam int IW = $clog2(NREQ);
  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH + 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  typedef logic [IW-1:0] tag_t;

  tag_t          prio_q, prio_d;
  tag_t          tag_mem_q [TAG_DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  tag_t grant, head_tag;
  logic any_req, is_full, is_empty, req_fire, resp_fire;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(TAG_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    logic found;
    tag_t cand;
    grant = prio_q;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = tag_t'((int'(prio_q) + k) % NREQ);
      if (!found && req_val[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  assign any_req  = |req_val;
  assign is_full  = (count_q == CW'(TAG_DEPTH));
  assign is_empty = (count_q == '0);

  // Reset gates the request side combinationally so nothing is offered while held low.
  assign gcd_req_val = reset & any_req & ~is_full;
  assign gcd_req_msg = req_msg[32*int'(grant) +: 32];
  assign req_fire    = gcd_req_val & gcd_req_rdy;
  assign req_rdy     = req_fire ? (ONE_HOT0 << grant) : '0;

  assign head_tag     = tag_mem_q[head_q];
  assign resp_msg     = gcd_resp_msg;
  assign resp_val     = (gcd_resp_val && !is_empty) ? (ONE_HOT0 << head_tag) : '0;
  assign gcd_resp_rdy = ~is_empty & resp_rdy[head_tag];
  assign resp_fire    = gcd_resp_val & gcd_resp_rdy;

  always_comb begin
    prio_d  = prio_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (req_fire) begin
      prio_d = (grant == tag_t'(NREQ - 1)) ? '0 : grant + 1'b1;
      tail_d = ptr_inc(tail_q);
    end
    if (resp_fire) head_d = ptr_inc(head_q);
    case ({req_fire, resp_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      prio_q  <= prio_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: tag storage is not reset; count_q alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (req_fire) tag_mem_q[tail_q] <= grant;
  end

`ifdef EX_GCD_ARBITER_PERF_EN
  logic [15:0] grants_q [NREQ];
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREQ; i++) grants_q[i] <= '0;
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_fire && grant == tag_t'(i) && grants_q[i] != 16'hffff)
          grants_q[i] <= grants_q[i] + 16'd1;
      end
      if (any_req && !req_fire && stall_q != 16'hffff) stall_q <= stall_q + 16'd1;
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_perf
    assign perf_grants[gi*16 +: 16] = grants_q[gi];
  end
  assign perf_stall = stall_q;
`endif

endmodule

// File: tb/tb_ex_gcd_arbiter.sv
// Bench for ex_gcd_arbiter: bench-side GCD unit, requesters and sinks, checked each cycle
// against a queue-based reference model and a per-requester result scoreboard.
module tb_ex_gcd_arbiter;

  localparam int NREQ      = 4;
  localparam int TAG_DEPTH = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ*32-1:0]  req_msg;
  logic [NREQ-1:0]     req_val, req_rdy, resp_val, resp_rdy;
  logic [15:0]         resp_msg, gcd_resp_msg;
  logic [31:0]         gcd_req_msg;
  logic                gcd_req_val, gcd_req_rdy, gcd_resp_val, gcd_resp_rdy;
`ifdef EX_GCD_ARBITER_PERF_EN
  logic [NREQ*16-1:0]  perf_grants;
  logic [15:0]         perf_stall;
`endif

  always #5 clk = ~clk;

  ex_gcd_arbiter #(.NREQ(NREQ), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_msg(req_msg), .req_val(req_val), .req_rdy(req_rdy),
    .resp_msg(resp_msg), .resp_val(resp_val), .resp_rdy(resp_rdy),
    .gcd_req_msg(gcd_req_msg), .gcd_req_val(gcd_req_val), .gcd_req_rdy(gcd_req_rdy),
    .gcd_resp_msg(gcd_resp_msg), .gcd_resp_val(gcd_resp_val), .gcd_resp_rdy(gcd_resp_rdy)
`ifdef EX_GCD_ARBITER_PERF_EN
    , .perf_grants(perf_grants), .perf_stall(perf_stall)
`endif
  );

  typedef struct { int res; int ready_cyc; } job_t;
  typedef struct { int idx; int val; } resp_t;

  int          n_vec = 0, n_bad = 0;
  int          m_prio;
  int          m_tags[$];
  logic [31:0] src_q[NREQ][$];
  int          exp_res[NREQ][$];
  job_t        gcd_q[$];
  resp_t       resp_log[$];
  int          grant_log[$];
  int          m_grants[NREQ];
  int          m_stall;
  int          cyc = 0, trace_col = 0;
  int          src_pct, sink_pct, grdy_pct, dly_min, dly_max;
  bit          force_gresp, refill;
  bit          last_fire, last_pop;
  int          last_g;
  logic        obs_gval;
  logic [NREQ-1:0] obs_rdy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int gcd_ref(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic logic [31:0] mk(input int a, input int b);
    logic [15:0] ha, hb;
    ha = 16'(a);
    hb = 16'(b);
    return {ha, hb};
  endfunction

  task automatic trace(input bit fire, input int g, input int count);
    if (fire) $write("%0d:%0d ", g, count);
    else      $write(".:%0d ", count);
    trace_col++;
    if (trace_col == 32) begin
      $write("\n");
      trace_col = 0;
    end
  endtask

  task automatic trace_nl();
    if (trace_col != 0) $write("\n");
    trace_col = 0;
  endtask

  function automatic bit busy();
    bit b;
    b = (m_tags.size() != 0) || (gcd_q.size() != 0);
    for (int i = 0; i < NREQ; i++) if (src_q[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  // One clock cycle: drive at posedge+1, compare against the model at negedge.
  task automatic cycle();
    int g, h, idx, r;
    bit full, fire, pop, has_head;
    logic [31:0] m, exp_rdy, exp_rv;
    if (refill)
      for (int i = 0; i < NREQ; i++)
        if (src_q[i].size() == 0) src_q[i].push_back(mk($urandom_range(300, 1), $urandom_range(300, 1)));
    for (int i = 0; i < NREQ; i++) begin
      req_val[i] = (src_q[i].size() != 0) && ($urandom_range(99) < src_pct);
      req_msg[i*32 +: 32] = (src_q[i].size() != 0) ? src_q[i][0] : 32'h0;
      resp_rdy[i] = ($urandom_range(99) < sink_pct);
    end
    gcd_req_rdy  = ($urandom_range(99) < grdy_pct);
    gcd_resp_val = force_gresp || (gcd_q.size() != 0 && gcd_q[0].ready_cyc <= cyc);
    gcd_resp_msg = (gcd_q.size() != 0) ? 16'(gcd_q[0].res) : 16'hdead;
    @(negedge clk);

    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_prio + k) % NREQ;
      if (g < 0 && req_val[idx]) g = idx;
    end
    full     = (m_tags.size() == TAG_DEPTH);
    fire     = (g >= 0) && !full && gcd_req_rdy;
    exp_rdy  = fire ? (32'd1 << g) : 32'd0;
    has_head = (m_tags.size() != 0);
    h        = has_head ? m_tags[0] : 0;
    pop      = has_head && gcd_resp_val && resp_rdy[h];
    exp_rv   = (has_head && gcd_resp_val) ? (32'd1 << h) : 32'd0;

    check("req_rdy", 32'(req_rdy), exp_rdy);
    check("gcd_req_val", 32'(gcd_req_val), 32'((g >= 0) && !full));
    if (g >= 0) check("gcd_req_msg", gcd_req_msg, src_q[g][0]);
    check("resp_val", 32'(resp_val), exp_rv);
    check("gcd_resp_rdy", 32'(gcd_resp_rdy), 32'(has_head && resp_rdy[h]));
    check("resp_msg", 32'(resp_msg), 32'(gcd_resp_msg));
    obs_gval = gcd_req_val;
    obs_rdy  = req_rdy;

    if (pop) begin
      if (exp_res[h].size() != 0) check("resp_data", 32'(resp_msg), 32'(exp_res[h].pop_front()));
      else check("resp_unexpected", 32'(h), 32'hffffffff);
      resp_log.push_back('{idx: h, val: int'(resp_msg)});
      void'(m_tags.pop_front());
      if (gcd_q.size() != 0) void'(gcd_q.pop_front());
    end
    if (fire) begin
      m = src_q[g].pop_front();
      r = gcd_ref(int'(m[31:16]), int'(m[15:0]));
      m_tags.push_back(g);
      exp_res[g].push_back(r);
      gcd_q.push_back('{res: r, ready_cyc: cyc + 1 + int'($urandom_range(dly_max, dly_min))});
      m_prio = (g + 1) % NREQ;
      grant_log.push_back(g);
      if (m_grants[g] < 65535) m_grants[g]++;
    end
    if (g >= 0 && !fire && m_stall < 65535) m_stall++;
    last_fire = fire;
    last_pop  = pop;
    last_g    = g;
    trace(fire, g, m_tags.size());
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_idle(input string tag, input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      cycle();
      n++;
    end
    check({tag, "_drain_timeout"}, 32'(busy()), 32'd0);
  endtask

  task automatic set_env(input int sp, input int kp, input int rp, input int dmin, input int dmax);
    src_pct = sp; sink_pct = kp; grdy_pct = rp; dly_min = dmin; dly_max = dmax;
  endtask

  // Asserts reset with every input active, checks the outputs drop at once, clears the model.
  task automatic do_reset();
    trace_nl();
    req_val = '1; resp_rdy = '1; gcd_req_rdy = 1'b1; gcd_resp_val = 1'b1;
    reset = 1'b0;
    #1;
    check("rst_req_rdy", 32'(req_rdy), 32'd0);
    check("rst_gcd_req_val", 32'(gcd_req_val), 32'd0);
    check("rst_resp_val", 32'(resp_val), 32'd0);
    check("rst_gcd_resp_rdy", 32'(gcd_resp_rdy), 32'd0);
    m_prio = 0;
    m_tags.delete(); gcd_q.delete(); resp_log.delete(); grant_log.delete();
    for (int i = 0; i < NREQ; i++) begin
      src_q[i].delete(); exp_res[i].delete(); m_grants[i] = 0;
    end
    m_stall = 0; force_gresp = 1'b0; refill = 1'b0;
    req_val = '0; req_msg = '0; resp_rdy = '0;
    gcd_req_rdy = 1'b0; gcd_resp_val = 1'b0; gcd_resp_msg = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    set_env(100, 100, 100, 0, 0);
    #2;
    do_reset();

    // Protocol violation: GCD response with no tag in flight is ignored.
    force_gresp = 1'b1;
    cycle();
    force_gresp = 1'b0;

    // Single requester, zero-delay GCD.
    src_q[0].push_back(mk(27, 15));
    src_q[0].push_back(mk(21, 49));
    run_idle("single", 50);
    check("single_n", 32'(resp_log.size()), 32'd2);
    if (resp_log.size() == 2) begin
      check("single_idx0", 32'(resp_log[0].idx), 32'd0);
      check("single_val0", 32'(resp_log[0].val), 32'd3);
      check("single_idx1", 32'(resp_log[1].idx), 32'd0);
      check("single_val1", 32'(resp_log[1].val), 32'd7);
    end

    // Fairness: all four request continuously.
    do_reset();
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < 3; j++)
        src_q[i].push_back(mk(12 * (i + 1) + j, 18 + j));
    src_q[1][0] = mk(40, 40);
    src_q[2][0] = mk(250, 190);
    run_idle("fair", 100);
    check("fair_n", 32'(grant_log.size()), 32'd12);
    for (int k = 0; k < grant_log.size() && k < 12; k++) check("fair_order", 32'(grant_log[k]), 32'(k % NREQ));
    if (resp_log.size() >= 3) begin
      check("fair_r1", 32'(resp_log[1].val), 32'd40);
      check("fair_r2", 32'(resp_log[2].val), 32'd10);
    end

    // Backpressure: sink stalls, FIFO fills, then a single pop frees one slot.
    do_reset();
    set_env(100, 0, 100, 0, 0);
    for (int j = 0; j < 3; j++) src_q[0].push_back(mk(6 + j, 4));
    repeat (4) cycle();
    check("bp_fires", 32'(grant_log.size()), 32'd2);
    check("bp_gcd_req_val", 32'(obs_gval), 32'd0);
    check("bp_req_rdy", 32'(obs_rdy), 32'd0);
    sink_pct = 100;
    cycle();
    check("bp_pop", 32'(last_pop), 32'd1);
    check("bp_no_fire_same", 32'(last_fire), 32'd0);
    cycle();
    check("bp_fire_next", 32'(last_fire), 32'd1);
    run_idle("bp", 50);

    // Steering with a slow GCD unit and a random sink.
    trace_nl();
    resp_log.delete();
    set_env(100, 50, 100, 5, 5);
    src_q[3].push_back(mk(91, 35));
    cycle();
    check("steer_first_grant", 32'(last_g), 32'd3);
    src_q[1].push_back(mk(64, 48));
    run_idle("steer", 100);
    check("steer_n", 32'(resp_log.size()), 32'd2);
    if (resp_log.size() == 2) begin
      check("steer_order0", 32'(resp_log[0].idx), 32'd3);
      check("steer_order1", 32'(resp_log[1].idx), 32'd1);
    end

    // Reset with two tags in flight.
    do_reset();
    set_env(100, 0, 100, 0, 0);
    src_q[2].push_back(mk(10, 4));
    src_q[3].push_back(mk(9, 6));
    repeat (3) cycle();
    check("midrst_full", 32'(obs_gval), 32'd0);
    do_reset();
    set_env(100, 100, 100, 0, 0);
    for (int i = 0; i < NREQ; i++) src_q[i].push_back(mk(5 * (i + 2), 15));
    cycle();
    check("midrst_fire", 32'(last_fire), 32'd1);
    check("midrst_grant0", 32'(last_g), 32'd0);
    run_idle("midrst", 50);

`ifdef EX_GCD_ARBITER_PERF_EN
    // Perf counters: nine grants to requester 2 with a stalling GCD unit.
    do_reset();
    set_env(100, 100, 50, 0, 2);
    for (int j = 0; j < 9; j++) src_q[2].push_back(mk(30 + j, 12));
    run_idle("perf", 300);
    for (int i = 0; i < NREQ; i++)
      check("perf_grants", 32'(perf_grants[i*16 +: 16]), (i == 2) ? 32'd9 : 32'd0);
    check("perf_stall", 32'(perf_stall), 32'(m_stall));
`endif

    // Randomized traffic, then drain.
    do_reset();
    set_env(60, 60, 70, 0, 4);
    refill = 1'b1;
    repeat (1500) cycle();
    refill = 1'b0;
    set_env(100, 100, 100, 0, 0);
    run_idle("random", 200);
`ifdef EX_GCD_ARBITER_PERF_EN
    for (int i = 0; i < NREQ; i++)
      check("rand_perf_grants", 32'(perf_grants[i*16 +: 16]), 32'(m_grants[i]));
    check("rand_perf_stall", 32'(perf_stall), 32'(m_stall));
`endif

    trace_nl();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
